// File: rtl/hazard_ctrl.sv
// Hazard detection, forwarding select and HI/LO busy tracking for the 5-stage MIPS pipeline.
// Stall/forward outputs are combinational from the D inputs and the E/M/W destination records.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] a3_d,
  input  logic [1:0] tnew_d,
  input  logic       md_use_d,
  input  logic       md_start_d,
  input  logic       md_div_d,
  output logic       stall,
  output logic       flush_e,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       fwd_rt_m,
  output logic       md_busy
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  logic [4:0] e_a3, e_rs, e_rt;
  logic [1:0] e_tnew;
  logic [4:0] m_a3, m_rt;
  logic [1:0] m_tnew;
  logic [4:0] w_a3;
  logic [1:0] w_tnew;
  logic [3:0] md_cnt;

  logic stall_rs, stall_rt, stall_md;
  logic [1:0] rt_m_sel;

  function automatic logic [1:0] age(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Nearest stage whose result is already available; a3 = 0 passed for a stage disables it.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] x,
    input logic [4:0] ea3, input logic [1:0] etn,
    input logic [4:0] ma3, input logic [1:0] mtn,
    input logic [4:0] wa3, input logic [1:0] wtn
  );
    if (x == 5'd0)                     return 2'd0;
    else if (ea3 == x && etn == 2'd0)  return 2'd1;
    else if (ma3 == x && mtn == 2'd0)  return 2'd2;
    else if (wa3 == x && wtn == 2'd0)  return 2'd3;
    else                               return 2'd0;
  endfunction

  // Only the nearest writer decides; an older writer hidden behind it is irrelevant.
  function automatic logic op_stall(
    input logic [4:0] x, input logic [1:0] tuse,
    input logic [4:0] ea3, input logic [1:0] etn,
    input logic [4:0] ma3, input logic [1:0] mtn
  );
    if (x == 5'd0)      return 1'b0;
    else if (ea3 == x)  return etn > tuse;
    else if (ma3 == x)  return mtn > tuse;
    else                return 1'b0;
  endfunction

  assign stall_rs = op_stall(rs_d, tuse_rs_d, e_a3, e_tnew, m_a3, m_tnew);
  assign stall_rt = op_stall(rt_d, tuse_rt_d, e_a3, e_tnew, m_a3, m_tnew);
  assign stall_md = md_use_d && (md_cnt != 4'd0);
  assign stall    = stall_rs || stall_rt || stall_md;
  assign flush_e  = stall;
  assign md_busy  = (md_cnt != 4'd0);

  assign fwd_rs_d = fwd_sel(rs_d, e_a3, e_tnew, m_a3, m_tnew, w_a3, w_tnew);
  assign fwd_rt_d = fwd_sel(rt_d, e_a3, e_tnew, m_a3, m_tnew, w_a3, w_tnew);
  assign fwd_rs_e = fwd_sel(e_rs, 5'd0, 2'd0, m_a3, m_tnew, w_a3, w_tnew);
  assign fwd_rt_e = fwd_sel(e_rt, 5'd0, 2'd0, m_a3, m_tnew, w_a3, w_tnew);
  assign rt_m_sel = fwd_sel(m_rt, 5'd0, 2'd0, 5'd0, 2'd0, w_a3, w_tnew);
  assign fwd_rt_m = (rt_m_sel == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      e_a3   <= 5'd0;
      e_tnew <= 2'd0;
      e_rs   <= 5'd0;
      e_rt   <= 5'd0;
      m_a3   <= 5'd0;
      m_tnew <= 2'd0;
      m_rt   <= 5'd0;
      w_a3   <= 5'd0;
      w_tnew <= 2'd0;
      md_cnt <= 4'd0;
    end else begin
      w_a3   <= m_a3;
      w_tnew <= age(m_tnew);
      m_a3   <= e_a3;
      m_tnew <= age(e_tnew);
      m_rt   <= e_rt;
      if (stall) begin
        e_a3   <= 5'd0;
        e_tnew <= 2'd0;
        e_rs   <= 5'd0;
        e_rt   <= 5'd0;
      end else begin
        e_a3   <= a3_d;
        e_tnew <= tnew_d;
        e_rs   <= rs_d;
        e_rt   <= rt_d;
      end
      if (md_start_d && !stall)
        md_cnt <= md_div_d ? DIV_LD : MULT_LD;
      else if (md_cnt != 4'd0)
        md_cnt <= md_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded bench for hazard_ctrl: a pipeline-list model predicts outputs, a negedge monitor compares.
module tb_hazard_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs_d, rt_d, a3_d;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic md_use_d, md_start_d, md_div_d;
  logic stall, flush_e, fwd_rt_m, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .a3_d(a3_d), .tnew_d(tnew_d),
    .md_use_d(md_use_d), .md_start_d(md_start_d), .md_div_d(md_div_d),
    .stall(stall), .flush_e(flush_e), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
  );

  // pipe[0] = E, pipe[1] = M, pipe[2] = W; tnew counts cycles until the result exists
  typedef struct {
    logic [4:0] a3;
    int         tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } rec_t;

  rec_t pipe [3];
  int   md_rem;
  logic [11:0] expq [$];
  int   tests = 0;
  int   fails = 0;
  logic last_stall = 1'b0;

  function automatic logic [1:0] near_fwd(input logic [4:0] x, input int first);
    for (int s = first; s < 3; s++)
      if (x != 5'd0 && pipe[s].a3 == x && pipe[s].tnew == 0) return 2'(s + 1);
    return 2'd0;
  endfunction

  function automatic logic op_stall(input logic [4:0] x, input logic [1:0] tuse);
    for (int s = 0; s < 2; s++)
      if (x != 5'd0 && pipe[s].a3 == x) return pipe[s].tnew > int'(tuse);
    return 1'b0;
  endfunction

  function automatic logic [11:0] model_out();
    logic st;
    logic [1:0] wm;
    st = op_stall(rs_d, tuse_rs_d) || op_stall(rt_d, tuse_rt_d) || (md_use_d && md_rem > 0);
    wm = near_fwd(pipe[1].rt, 2);
    return {st, st, near_fwd(rs_d, 0), near_fwd(rt_d, 0),
            near_fwd(pipe[0].rs, 1), near_fwd(pipe[0].rt, 1), wm == 2'd3, md_rem > 0};
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 3; s++) begin
      pipe[s].a3 = 5'd0; pipe[s].tnew = 0; pipe[s].rs = 5'd0; pipe[s].rt = 5'd0;
    end
    md_rem = 0;
  endtask

  task automatic cyc(input logic rst, input logic chk,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic [1:0] urs, input logic [1:0] urt,
                     input logic [4:0] a3, input logic [1:0] tn,
                     input logic mu, input logic ms, input logic mdv);
    logic [11:0] e;
    reset = rst; rs_d = rs; rt_d = rt; tuse_rs_d = urs; tuse_rt_d = urt;
    a3_d = a3; tnew_d = tn; md_use_d = mu; md_start_d = ms; md_div_d = mdv;
    e = model_out();
    if (chk) expq.push_back(e);
    last_stall = e[11];
    @(posedge clk);
    if (rst) clear_model();
    else begin
      pipe[2] = pipe[1];
      pipe[2].tnew = (pipe[1].tnew > 0) ? pipe[1].tnew - 1 : 0;
      pipe[1] = pipe[0];
      pipe[1].tnew = (pipe[0].tnew > 0) ? pipe[0].tnew - 1 : 0;
      if (e[11]) begin
        pipe[0].a3 = 5'd0; pipe[0].tnew = 0; pipe[0].rs = 5'd0; pipe[0].rt = 5'd0;
      end else begin
        pipe[0].a3 = a3; pipe[0].tnew = int'(tn); pipe[0].rs = rs; pipe[0].rt = rt;
      end
      if (ms && !e[11]) md_rem = mdv ? DC : MC;
      else if (md_rem > 0) md_rem--;
    end
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Hold the D instruction until it is accepted, as the real front end would.
  task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] urs, input logic [1:0] urt,
                       input logic [4:0] a3, input logic [1:0] tn,
                       input logic mu, input logic ms, input logic mdv);
    int n;
    n = 0;
    do begin
      cyc(1'b0, 1'b1, rs, rt, urs, urt, a3, tn, mu, ms, mdv);
      n++;
    end while (last_stall && n < 40);
    if (last_stall) begin
      tests++; fails++;
      $display("FAIL issue_timeout stall still high after %0d cycles, required release", n);
    end
  endtask

  logic [11:0] mon_exp, mon_got;
  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        mon_exp = expq.pop_front();
        mon_got = {stall, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy};
        tests++;
        if (mon_got !== mon_exp) begin
          fails++;
          $display("FAIL outputs t=%0t got=%03h required=%03h (stall,flush,rs_d,rt_d,rs_e,rt_e,rt_m,busy)",
                   $time, mon_got, mon_exp);
        end
      end
    end
  end

  logic [4:0] r_rs, r_rt, r_a3;
  logic [1:0] r_urs, r_urt, r_tn;
  logic r_mu, r_ms, r_mdv;

  initial begin
    clear_model();
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    nop(2);
    // load-use
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
    issue(5'd8, 5'd0, 2'd1, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    nop(3);
    // back-to-back ALU: branch then ALU consumer
    issue(5'd1, 5'd2, 2'd1, 2'd1, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
    issue(5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    nop(3);
    issue(5'd1, 5'd2, 2'd1, 2'd1, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
    issue(5'd9, 5'd9, 2'd1, 2'd2, 5'd11, 2'd1, 1'b0, 1'b0, 1'b0);
    nop(3);
    // shadowed older writer
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
    issue(5'd10, 5'd10, 2'd1, 2'd2, 5'd12, 2'd1, 1'b0, 1'b0, 1'b0);
    nop(3);
    // divide, then mflo held until idle; then mult while busy
    issue(5'd4, 5'd5, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd12, 2'd1, 1'b1, 1'b0, 1'b0);
    issue(5'd4, 5'd5, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    issue(5'd4, 5'd5, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    nop(6);
    // reset in the middle of a divide
    issue(5'd4, 5'd5, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd12, 2'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd12, 2'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd12, 2'd1, 1'b1, 1'b0, 1'b0);
    nop(2);
    // jal link then jr, then $0 reads against a no-write E
    issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
    issue(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    issue(5'd0, 5'd0, 2'd0, 2'd0, 5'd3, 2'd2, 1'b0, 1'b0, 1'b0);
    issue(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    nop(3);
    // random traffic on a small register set so hazards are frequent
    for (int i = 0; i < 2000; i++) begin
      if (!last_stall) begin
        r_rs  = 5'($urandom_range(0, 3));
        r_rt  = 5'($urandom_range(0, 3));
        r_urs = 2'($urandom_range(0, 3));
        r_urt = 2'($urandom_range(0, 3));
        r_a3  = 5'($urandom_range(0, 3));
        r_tn  = 2'($urandom_range(0, 2));
        r_mu  = ($urandom_range(0, 7) == 0);
        r_ms  = r_mu && ($urandom_range(0, 1) == 1);
        r_mdv = 1'($urandom_range(0, 1));
      end
      cyc(($urandom_range(0, 299) == 0), 1'b1, r_rs, r_rt, r_urs, r_urt, r_a3, r_tn, r_mu, r_ms, r_mdv);
    end
    nop(2);
    repeat (2) @(posedge clk);
    if (expq.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_drain %0d entries left, required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
